// File: rtl/bypass_scan_pkg.sv
// Shared types and constants for the wake-up bypass scan controller.
package bypass_scan_pkg;

    localparam int unsigned BYPASS_WIDTH = 24;

    // Stage-2 reset image of the bypass register, mirrored by software and benches.
    localparam logic [BYPASS_WIDTH-1:0] BYPASS_RST_WORD = 24'h0007FF;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit,
        StDone
    } scan_state_e;

endpackage

// File: rtl/bypass_scan_ctrl_if.sv
// Config-side request/response bundle between the always-on config logic and the scan controller.
interface bypass_scan_ctrl_if
    import bypass_scan_pkg::*;
#(
    parameter int unsigned WIDTH = BYPASS_WIDTH,
    parameter int unsigned DIV_W = 8
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_data;
    logic             cfg_commit;
    logic [DIV_W-1:0] shift_div;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rdata;

    modport master (
        output cfg_valid, cfg_data, cfg_commit, shift_div,
        input  cfg_ready, busy, done, rdata
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_commit, shift_div,
        output cfg_ready, busy, done, rdata
    );

endinterface

// File: rtl/bypass_scan_ctrl.sv
// Serialises a bypass word MSB-first into the wake-up bypass chain, optionally commits it to
// stage 2, and returns the displaced stage-1 contents as readback.
module bypass_scan_ctrl
    import bypass_scan_pkg::*;
#(
    parameter int unsigned WIDTH = BYPASS_WIDTH,
    parameter int unsigned DIV_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    bypass_scan_ctrl_if.slave  cfg,
    output logic               wu_bypass_data_in,
    output logic               wu_bypass_en,
    output logic               wu_bypass_shift,
    input  logic               wu_bypass_data_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    scan_state_e      state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             commit_q, commit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             en_q, en_d;
    logic             shift_q, shift_d;
    logic             din_q, din_d;
    logic             done_q, done_d;
    logic             accept;
    logic [DIV_W-1:0] div_eff;

    // The done_o cycle still counts as part of the transfer, so ready waits one more cycle.
    assign cfg.cfg_ready = !rst_i && (state_q == StIdle) && !done_q;
    assign cfg.busy      = (state_q != StIdle) || done_q;
    assign cfg.done      = done_q;
    assign cfg.rdata     = rdata_q;

    assign wu_bypass_data_in = din_q;
    assign wu_bypass_en      = en_q;
    assign wu_bypass_shift   = shift_q;

    assign accept  = cfg.cfg_valid && cfg.cfg_ready;
    assign div_eff = (cfg.shift_div == '0) ? DIV_W'(1) : cfg.shift_div;

    // Chain MSB is captured while the enable is on the pins, i.e. just before the chain moves.
    assign rd_d = en_q ? {rd_q[WIDTH-2:0], wu_bypass_data_out} : rd_q;

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        rdata_d   = rdata_q;
        commit_d  = commit_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        en_d      = 1'b0;
        shift_d   = 1'b0;
        din_d     = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    sh_d      = cfg.cfg_data;
                    commit_d  = cfg.cfg_commit;
                    div_d     = div_eff;
                    div_cnt_d = div_eff - 1'b1;
                    bit_cnt_d = CNT_W'(WIDTH - 1);
                    state_d   = StShift;
                end
            end
            StShift: begin
                din_d = sh_q[WIDTH-1];
                if (div_cnt_q == '0) begin
                    en_d      = 1'b1;
                    sh_d      = {sh_q[WIDTH-2:0], 1'b0};
                    div_cnt_d = div_q - 1'b1;
                    if (bit_cnt_q == '0) begin
                        state_d = commit_q ? StCommit : StDone;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            StCommit: begin
                shift_d = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                // Without a commit cycle the last bit is still being captured here.
                done_d  = 1'b1;
                rdata_d = rd_d;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            sh_q      <= '0;
            rd_q      <= '0;
            rdata_q   <= '0;
            commit_q  <= 1'b0;
            div_q     <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            en_q      <= 1'b0;
            shift_q   <= 1'b0;
            din_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            rd_q      <= rd_d;
            rdata_q   <= rdata_d;
            commit_q  <= commit_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            en_q      <= en_d;
            shift_q   <= shift_d;
            din_q     <= din_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_bypass_scan_ctrl.sv
// Directed bench for bypass_scan_ctrl with a two-stage bypass chain model and readback scoreboard.
module tb_bypass_scan_ctrl;
    import bypass_scan_pkg::*;

    localparam int unsigned W = BYPASS_WIDTH;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic wu_bypass_data_in, wu_bypass_en, wu_bypass_shift, wu_bypass_data_out;

    always #5 clk = ~clk;

    bypass_scan_ctrl_if #(.WIDTH(W), .DIV_W(8)) cfg ();

    bypass_scan_ctrl #(.WIDTH(W), .DIV_W(8)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .cfg                (cfg),
        .wu_bypass_data_in  (wu_bypass_data_in),
        .wu_bypass_en       (wu_bypass_en),
        .wu_bypass_shift    (wu_bypass_shift),
        .wu_bypass_data_out (wu_bypass_data_out)
    );

    // Bypass register model: stage 1 shifts on en, stage 2 loads stage 1 on shift.
    logic [W-1:0] stage1 = '0;
    logic [W-1:0] stage2 = BYPASS_RST_WORD;
    always @(posedge clk) begin
        if (wu_bypass_en) stage1 <= {stage1[W-2:0], wu_bypass_data_in};
        if (wu_bypass_shift) stage2 <= stage1;
    end
    assign wu_bypass_data_out = stage1[W-1];

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] ref_s1 = '0;
    logic [W-1:0] ref_s2 = BYPASS_RST_WORD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string name, input logic [W-1:0] data, input bit commit,
                        input logic [7:0] div, input bit junk);
        int d, en_cnt, shift_cnt, shift_k, done_cnt, done_k, ready_k;
        int overlap, pos_err, stab_err, last_change, exp_done, guard;
        logic [W-1:0] bits;
        logic din_prev;
        d = (div == 8'd0) ? 1 : int'(div);
        @(negedge clk);
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_data   = data;
        cfg.cfg_commit = commit;
        cfg.shift_div  = div;
        guard = 0;
        while (!cfg.cfg_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({name, "/accept"}, 32'(cfg.cfg_ready), 32'd1);
        sb_q.push_back(ref_s1);
        ref_s1 = data;
        if (commit) ref_s2 = data;
        en_cnt = 0; shift_cnt = 0; shift_k = -1; done_cnt = 0; done_k = -1; ready_k = -1;
        overlap = 0; pos_err = 0; stab_err = 0; last_change = 0; bits = '0; din_prev = 1'b0;
        exp_done = W * d + (commit ? 2 : 1);
        for (int k = 0; k <= exp_done + 4; k++) begin
            @(negedge clk);
            if (cfg.cfg_ready && ready_k < 0) ready_k = k;
            if (wu_bypass_data_in !== din_prev) begin
                last_change = k;
                din_prev = wu_bypass_data_in;
            end
            if (wu_bypass_en) begin
                if (k != d * (en_cnt + 1)) pos_err++;
                if (k - last_change < d - 1) stab_err++;
                bits = {bits[W-2:0], wu_bypass_data_in};
                en_cnt++;
            end
            if (wu_bypass_shift) begin
                shift_cnt++;
                shift_k = k;
                if (wu_bypass_en) overlap++;
            end
            if (cfg.done) begin
                done_cnt++;
                done_k = k;
                check({name, "/sb_depth"}, sb_q.size(), 32'd1);
                if (sb_q.size() > 0) check({name, "/rdata"}, 32'(cfg.rdata), 32'(sb_q.pop_front()));
            end
            if (junk && done_k < 0) cfg.cfg_data = W'($urandom);
            else cfg.cfg_valid = 1'b0;
        end
        cfg.cfg_valid = 1'b0;
        check({name, "/en_count"}, en_cnt, W);
        check({name, "/serial_bits"}, 32'(bits), 32'(data));
        check({name, "/en_spacing"}, pos_err, 0);
        check({name, "/data_in_stable"}, stab_err, 0);
        check({name, "/shift_count"}, shift_cnt, commit ? 1 : 0);
        check({name, "/shift_cycle"}, shift_k, commit ? W * d + 1 : -1);
        check({name, "/en_shift_overlap"}, overlap, 0);
        check({name, "/done_count"}, done_cnt, 1);
        check({name, "/done_cycle"}, done_k, exp_done);
        check({name, "/ready_cycle"}, ready_k, exp_done + 1);
        check({name, "/stage1"}, 32'(stage1), 32'(ref_s1));
        check({name, "/stage2"}, 32'(stage2), 32'(ref_s2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] abort_data, partial;
        int en_seen, guard, late_done, late_shift;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_data = '0;
        cfg.cfg_commit = 1'b0;
        cfg.shift_div = 8'd1;
        repeat (3) @(negedge clk);
        check("reset/ready", 32'(cfg.cfg_ready), 32'd0);
        check("reset/busy", 32'(cfg.busy), 32'd0);
        check("reset/done", 32'(cfg.done), 32'd0);
        check("reset/en", 32'(wu_bypass_en), 32'd0);
        check("reset/shift", 32'(wu_bypass_shift), 32'd0);
        check("reset/data_in", 32'(wu_bypass_data_in), 32'd0);
        check("reset/rdata", 32'(cfg.rdata), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        check("post_reset/ready", 32'(cfg.cfg_ready), 32'd1);

        xfer("load1", 24'hA5C3F0, 1'b1, 8'd1, 1'b0);
        xfer("load2", 24'h123456, 1'b1, 8'd1, 1'b0);
        xfer("nocommit", 24'hFFFFFF, 1'b0, 8'd1, 1'b0);
        xfer("div0", 24'h5A5A5A, 1'b1, 8'd0, 1'b0);
        xfer("div3", 24'hC0FFEE, 1'b0, 8'd3, 1'b0);
        xfer("busy_valid", 24'h3C3C3C, 1'b1, 8'd2, 1'b1);

        // Abort a commit transfer after ten bits have gone into the chain.
        abort_data = 24'hABCDEF;
        partial = {ref_s1[W-11:0], abort_data[W-1:W-10]};
        @(negedge clk);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_data = abort_data;
        cfg.cfg_commit = 1'b1;
        cfg.shift_div = 8'd1;
        guard = 0;
        while (!cfg.cfg_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        en_seen = 0;
        guard = 0;
        while (en_seen < 10 && guard < 40) begin
            @(negedge clk);
            cfg.cfg_valid = 1'b0;
            if (wu_bypass_en) en_seen++;
            guard++;
        end
        check("abort/en_before_reset", en_seen, 10);
        rst_i = 1'b1;
        @(negedge clk);
        check("abort/en", 32'(wu_bypass_en), 32'd0);
        check("abort/shift", 32'(wu_bypass_shift), 32'd0);
        check("abort/done", 32'(cfg.done), 32'd0);
        check("abort/busy", 32'(cfg.busy), 32'd0);
        check("abort/ready_in_reset", 32'(cfg.cfg_ready), 32'd0);
        check("abort/rdata_cleared", 32'(cfg.rdata), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        check("abort/ready_after", 32'(cfg.cfg_ready), 32'd1);
        late_done = 0;
        late_shift = 0;
        repeat (30) begin
            @(negedge clk);
            if (cfg.done) late_done++;
            if (wu_bypass_shift || wu_bypass_en) late_shift++;
        end
        check("abort/no_done", late_done, 0);
        check("abort/no_chain_activity", late_shift, 0);
        check("abort/stage2", 32'(stage2), 32'(ref_s2));
        check("abort/stage1", 32'(stage1), 32'(partial));
        ref_s1 = partial;

        xfer("after_abort", 24'h0F0F0F, 1'b1, 8'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
